rf_plus_alu: RTL and testbench

Datapath slice of the multicycle RISC core: an 8 x 16-bit register file, an ID/EXE operand buffer and a 16-bit add/subtract ALU with C/Z/N flags. Sequencing comes from the external multicycle controller through single-bit control inputs. Instruction fields come from Ins. Memory read data returns on WBData. PSW flag storage lives outside this block; the stored carry is supplied back on PSW_C.

---
 rtl/rf_plus_alu.sv | 121 ++++++++++++
 tb/tb_rf_plus_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_plus_alu.sv
// Datapath slice of the multicycle core: 8 x 16-bit register file, ID/EXE
// operand buffer and a 16-bit add/subtract ALU producing C/Z/N.
module rf_plus_alu (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] Ins,
    input  logic [15:0] WBData,
    input  logic        WBRF,
    input  logic        WBresource,
    input  logic        RBresource,
    input  logic        OprandB,
    input  logic        LI,
    input  logic        Buff_IDEXE,
    input  logic        PSW_C,
    input  logic        ALUop,
    input  logic        Flag,
    output logic [7:0]  Rm,
    output logic [7:0]  Rd,
    output logic [15:0] OutR,
    output logic [15:0] IL_EXE,
    output logic [15:0] Sum,
    output logic        C,
    output logic        Z,
    output logic        N
);

    // 17-bit add/subtract; bit 16 is carry out for add, borrow out for subtract
    function automatic logic [16:0] alu_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        sub,
                                          input logic        cin);
        logic [16:0] r;
        if (sub)
            r = {1'b0, a} - {1'b0, b} - {16'b0, cin};
        else
            r = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        return r;
    endfunction

    logic [15:0] regs [8];

    logic [2:0]  rd_idx;
    logic [2:0]  rm_idx;
    logic [2:0]  rb_idx;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] wb_val;
    logic [15:0] exe_result;

    logic [15:0] opa_p1;
    logic [15:0] opb_p1;
    logic [15:0] il_p1;
    logic        lisel_p1;

    logic [16:0] alu_res;
    logic        cin;
    logic        unused_ins;

    assign unused_ins = ^Ins[15:11];

    assign rd_idx = Ins[10:8];
    assign rm_idx = Ins[7:5];
    assign rb_idx = RBresource ? Ins[10:8] : Ins[4:2];

    // Combinational read ports: after a write edge they already show the new value
    always_comb begin
        data_a = regs[rm_idx];
        data_b = regs[rb_idx];
    end

    assign OutR = data_a;
    assign Rm   = data_a[7:0];
    assign Rd   = regs[rd_idx][7:0];

    assign exe_result = lisel_p1 ? il_p1 : Sum;
    assign wb_val     = WBresource ? exe_result : WBData;

    // Register file write port; every register including R0 is writable
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else if (WBRF) begin
            regs[rd_idx] <= wb_val;
        end
    end

    // ---- ID -> EXE boundary ----
    // Operand / immediate buffer; loads see pre-write register contents on a shared edge
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            opa_p1 <= '0;
            opb_p1 <= '0;
            il_p1  <= '0;
        end else if (Buff_IDEXE) begin
            opa_p1 <= data_a;
            opb_p1 <= OprandB ? {11'b0, Ins[4:0]} : data_b;
            il_p1  <= LI ? {8'h00, Ins[7:0]} : {Ins[7:0], data_b[7:0]};
        end
    end

    // Result-source select: a buffer load arms the immediate path; the next
    // non-load edge (ALU EXE cycle, or the LHI/LLI write-back edge which still
    // samples the armed value) returns the write-back source to the ALU sum
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            lisel_p1 <= 1'b0;
        else
            lisel_p1 <= Buff_IDEXE;
    end

    // ---- EXE (combinational from buffered operands) ----
    assign cin     = Flag & PSW_C;
    assign alu_res = alu_f(opa_p1, opb_p1, ALUop, cin);
    assign Sum     = alu_res[15:0];
    assign C       = alu_res[16];
    assign Z       = (alu_res[15:0] == 16'h0000);
    assign N       = alu_res[15];
    assign IL_EXE  = il_p1;

endmodule

// File: tb/tb_rf_plus_alu.sv
// Directed self-checking bench for rf_plus_alu.
module tb_rf_plus_alu;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] Ins;
    logic [15:0] WBData;
    logic        WBRF;
    logic        WBresource;
    logic        RBresource;
    logic        OprandB;
    logic        LI;
    logic        Buff_IDEXE;
    logic        PSW_C;
    logic        ALUop;
    logic        Flag;
    logic [7:0]  Rm;
    logic [7:0]  Rd;
    logic [15:0] OutR;
    logic [15:0] IL_EXE;
    logic [15:0] Sum;
    logic        C;
    logic        Z;
    logic        N;

    int passed = 0;
    int total  = 0;

    rf_plus_alu dut (
        .clk        (clk),
        .Reset      (Reset),
        .Ins        (Ins),
        .WBData     (WBData),
        .WBRF       (WBRF),
        .WBresource (WBresource),
        .RBresource (RBresource),
        .OprandB    (OprandB),
        .LI         (LI),
        .Buff_IDEXE (Buff_IDEXE),
        .PSW_C      (PSW_C),
        .ALUop      (ALUop),
        .Flag       (Flag),
        .Rm         (Rm),
        .Rd         (Rd),
        .OutR       (OutR),
        .IL_EXE     (IL_EXE),
        .Sum        (Sum),
        .C          (C),
        .Z          (Z),
        .N          (N)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Ins = '0; WBData = '0; WBRF = 1'b0; WBresource = 1'b0;
        RBresource = 1'b0; OprandB = 1'b0; LI = 1'b0; Buff_IDEXE = 1'b0;
        PSW_C = 1'b0; ALUop = 1'b0; Flag = 1'b0;

        // reset state
        #12;
        chk("rst_sum", Sum, 16'h0000);
        chk("rst_z", {15'b0, Z}, 16'h0001);
        chk("rst_c", {15'b0, C}, 16'h0000);
        chk("rst_n", {15'b0, N}, 16'h0000);
        chk("rst_il", IL_EXE, 16'h0000);
        chk("rst_outr", OutR, 16'h0000);
        Reset = 1'b1;

        // 1: write R0..R7 = 1000+i from WBData
        WBRF = 1'b1; WBresource = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Ins    = 16'(i) << 8;
            WBData = 16'h1000 + 16'(i);
            tick();
        end
        WBRF = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Ins = 16'(i) << 8;
            #1;
            chk($sformatf("wr_rd%0d", i), {8'h00, Rd}, 16'(i));
        end
        Ins = 16'h0060; #1;
        chk("outr_r3", OutR, 16'h1003);
        chk("rm_r3", {8'h00, Rm}, 16'h0003);

        // 2: LLI into R3
        Ins = 16'h03A5; LI = 1'b1; Buff_IDEXE = 1'b1;
        tick();
        Buff_IDEXE = 1'b0;
        chk("lli_il", IL_EXE, 16'h00A5);
        WBRF = 1'b1; WBresource = 1'b1;
        tick();
        WBRF = 1'b0;
        Ins = 16'h0360; #1;
        chk("lli_wb_outr", OutR, 16'h00A5);
        chk("lli_wb_rd", {8'h00, Rd}, 16'h00A5);

        // 3: LHI with R2 = 1002 through read port B = Rd field
        Ins = 16'h025C; RBresource = 1'b1; LI = 1'b0; Buff_IDEXE = 1'b1;
        tick();
        Buff_IDEXE = 1'b0; RBresource = 1'b0;
        chk("lhi_il", IL_EXE, 16'h5C02);
        WBRF = 1'b1; WBresource = 1'b1;
        tick();
        WBRF = 1'b0;
        Ins = 16'h0040; #1;
        chk("lhi_wb_outr", OutR, 16'h5C02);

        // 4: ADD / ADC with R4 = FFFF, R5 = 0001, result to R6
        WBRF = 1'b1; WBresource = 1'b0;
        Ins = 16'h0400; WBData = 16'hFFFF; tick();
        Ins = 16'h0500; WBData = 16'h0001; tick();
        WBRF = 1'b0;
        Ins = 16'h0694; OprandB = 1'b0; Buff_IDEXE = 1'b1; ALUop = 1'b0; Flag = 1'b0; PSW_C = 1'b0;
        tick();
        Buff_IDEXE = 1'b0;
        chk("add_sum", Sum, 16'h0000);
        chk("add_c", {15'b0, C}, 16'h0001);
        chk("add_z", {15'b0, Z}, 16'h0001);
        chk("add_n", {15'b0, N}, 16'h0000);
        Flag = 1'b1; PSW_C = 1'b1; #1;
        chk("adc_sum", Sum, 16'h0001);
        chk("adc_c", {15'b0, C}, 16'h0001);
        chk("adc_z", {15'b0, Z}, 16'h0000);
        tick();                                  // EXE edge
        WBRF = 1'b1; WBresource = 1'b1;
        tick();                                  // write-back edge
        WBRF = 1'b0; Flag = 1'b0; PSW_C = 1'b0;
        Ins = 16'h00C0; #1;
        chk("adc_wb_r6", OutR, 16'h0001);

        // 5: SUB / SBB with immediate operand
        WBRF = 1'b1; WBresource = 1'b0; Ins = 16'h0100; WBData = 16'h0003; tick();
        WBRF = 1'b0;
        Ins = 16'h0025; OprandB = 1'b1; Buff_IDEXE = 1'b1; ALUop = 1'b1;
        tick();
        Buff_IDEXE = 1'b0;
        chk("sub_sum", Sum, 16'hFFFE);
        chk("sub_c", {15'b0, C}, 16'h0001);
        chk("sub_n", {15'b0, N}, 16'h0001);
        chk("sub_z", {15'b0, Z}, 16'h0000);
        Ins = 16'h00E0; #1;
        chk("buf_hold", Sum, 16'hFFFE);
        WBRF = 1'b1; Ins = 16'h0100; WBData = 16'h0005; tick();
        WBRF = 1'b0;
        Ins = 16'h0025; Buff_IDEXE = 1'b1;
        tick();
        Buff_IDEXE = 1'b0;
        Flag = 1'b1; PSW_C = 1'b1; #1;
        chk("sbb_sum", Sum, 16'hFFFF);
        chk("sbb_c", {15'b0, C}, 16'h0001);
        chk("sbb_n", {15'b0, N}, 16'h0001);
        PSW_C = 1'b0; #1;
        chk("sbb_nc_sum", Sum, 16'h0000);
        chk("sbb_nc_c", {15'b0, C}, 16'h0000);
        chk("sbb_nc_z", {15'b0, Z}, 16'h0001);
        Flag = 1'b0; PSW_C = 1'b1; #1;
        chk("noflag_cin_sum", Sum, 16'h0000);
        PSW_C = 1'b0; ALUop = 1'b0;

        // same-edge write and buffer load: buffer sees old R7
        Ins = 16'h07E0; WBRF = 1'b1; WBresource = 1'b0; WBData = 16'hBEEF;
        Buff_IDEXE = 1'b1; OprandB = 1'b1;
        tick();
        WBRF = 1'b0; Buff_IDEXE = 1'b0;
        chk("same_edge_sum", Sum, 16'h1007);
        chk("same_edge_outr", OutR, 16'hBEEF);

        // 6: WBRF=0 blocks writes while WBData toggles
        Ins = 16'h07E0;
        for (int k = 0; k < 4; k++) begin
            WBData = 16'h5555 ^ (16'(k) * 16'h3333);
            WBresource = k[0];
            tick();
        end
        chk("nowr_r7", OutR, 16'hBEEF);
        Ins = 16'h0360; #1;
        chk("nowr_r3", OutR, 16'h00A5);

        // asynchronous reset mid-cycle
        Ins = 16'h07E0; #2;
        Reset = 1'b0; #1;
        chk("arst_outr", OutR, 16'h0000);
        chk("arst_rd", {8'h00, Rd}, 16'h0000);
        chk("arst_sum", Sum, 16'h0000);
        chk("arst_z", {15'b0, Z}, 16'h0001);
        chk("arst_c", {15'b0, C}, 16'h0000);
        chk("arst_il", IL_EXE, 16'h0000);
        Ins = 16'h0460; #1;
        chk("arst_r3", OutR, 16'h0000);
        Reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
